vector_sequencer: RTL and testbench

// - Synthesisable stimulus/response test sequencer for the board test environments.
// - Replays NUM_VEC stimulus words from an internal ROM onto a board-facing stimulus bus (switch-equivalent).
// - Samples the DUT response (LED-equivalent) after a settle interval and compares it, with a per-vector mask, against the expected value.
// - Reports pass/fail, a saturating error count and the index of the first failing vector; it replaces hand-timed testbench stimulus.

---
 rtl/vector_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_vector_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_sequencer.sv
// Replays NUM_VEC {mask,exp,stim} words onto stim_o and checks resp_i against exp under mask.
// Latency: SETTLE+2 cycles per vector (LOAD, SETTLE x n, CHECK); NUM_VEC*(SETTLE+2) cycles from start to done.
// No backpressure: start is ignored while busy, abort ends a run next cycle. Macro VSEQ_STOP_ON_ERR_EN ends the run on the first mismatch.
// The vector image is supplied as the packed parameter ROM_IMAGE, vector 0 in the least significant word.
module vector_sequencer #(
   parameter int STIM_W  = 18,
   parameter int RESP_W  = 24,
   parameter int NUM_VEC = 64,
   parameter int SETTLE  = 2,
   parameter int CNT_W   = 8,
   parameter logic [NUM_VEC*(2*RESP_W+STIM_W)-1:0] ROM_IMAGE = '0,
   localparam int IDX_W  = $clog2(NUM_VEC+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [STIM_W-1:0] stim_o,
   input  logic [RESP_W-1:0] resp_i,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [IDX_W-1:0]  first_err,
   output logic [IDX_W-1:0]  vec_idx
);

   localparam int WORD_W = 2*RESP_W + STIM_W;
   localparam int ROM_AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
   localparam int ROM_D  = 1 << ROM_AW;
   localparam int SC_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(NUM_VEC);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC-1);
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SETTLE-1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  vec_idx_q, vec_idx_d;
   logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic [STIM_W-1:0] stim_q, stim_d;
   logic [RESP_W-1:0] exp_q, exp_d;
   logic [RESP_W-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [IDX_W-1:0]  first_err_q, first_err_d;
   logic              aborted_q, aborted_d;

   logic [WORD_W-1:0] rom [ROM_D];
   logic [WORD_W-1:0] rom_word;
   logic              mism;

   // Unpack the image; the array is padded to a power of two so the index width matches exactly.
   for (genvar g = 0; g < ROM_D; g++) begin : g_rom
      if (g < NUM_VEC) begin : g_used
         assign rom[g] = ROM_IMAGE[g*WORD_W +: WORD_W];
      end else begin : g_pad
         assign rom[g] = '0;
      end
   end

   assign rom_word = rom[vec_idx_q[ROM_AW-1:0]];
   // A zero mask bit makes that response bit a don't-care, so an all-zero mask never fails.
   assign mism     = |((resp_i ^ exp_q) & mask_q);

   // State and datapath registers; reset clears every result so no partial run survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         vec_idx_q    <= '0;
         settle_cnt_q <= '0;
         stim_q       <= '0;
         exp_q        <= '0;
         mask_q       <= '0;
         err_cnt_q    <= '0;
         first_err_q  <= IDX_NONE;
         aborted_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_idx_q    <= vec_idx_d;
         settle_cnt_q <= settle_cnt_d;
         stim_q       <= stim_d;
         exp_q        <= exp_d;
         mask_q       <= mask_d;
         err_cnt_q    <= err_cnt_d;
         first_err_q  <= first_err_d;
         aborted_q    <= aborted_d;
      end
   end

   // Next-state logic: sequence LOAD -> SETTLE -> CHECK per vector, abort overrides everything.
   always_comb begin
      state_d      = state_q;
      vec_idx_d    = vec_idx_q;
      settle_cnt_d = settle_cnt_q;
      stim_d       = stim_q;
      exp_d        = exp_q;
      mask_d       = mask_q;
      err_cnt_d    = err_cnt_q;
      first_err_d  = first_err_q;
      aborted_d    = aborted_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // abort wins over a simultaneous start and leaves the result untouched
            if (start && !abort) begin
               state_d     = ST_LOAD;
               vec_idx_d   = '0;
               err_cnt_d   = '0;
               first_err_d = IDX_NONE;
               aborted_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else begin
               stim_d       = rom_word[STIM_W-1:0];
               exp_d        = rom_word[STIM_W +: RESP_W];
               mask_d       = rom_word[STIM_W+RESP_W +: RESP_W];
               settle_cnt_d = '0;
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else if (settle_cnt_q == SC_LAST) begin
               state_d = ST_CHECK;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         ST_CHECK: begin
            if (abort) begin
               // the compare of this cycle is discarded
               state_d   = ST_DONE;
               aborted_d = 1'b1;
            end else begin
               if (mism) begin
                  if (err_cnt_q != {CNT_W{1'b1}}) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
                  if (first_err_q == IDX_NONE) begin
                     first_err_d = vec_idx_q;
                  end
               end
`ifdef VSEQ_STOP_ON_ERR_EN
               if (mism || (vec_idx_q == IDX_LAST)) begin
                  state_d = ST_DONE;
               end else begin
                  vec_idx_d = vec_idx_q + 1'b1;
                  state_d   = ST_LOAD;
               end
`else
               if (vec_idx_q == IDX_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  vec_idx_d = vec_idx_q + 1'b1;
                  state_d   = ST_LOAD;
               end
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign stim_o    = stim_q;
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
   assign done      = (state_q == ST_DONE);
   assign pass      = done && (err_cnt_q == '0) && !aborted_q;
   assign err_count = err_cnt_q;
   assign first_err = first_err_q;
   assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_vector_sequencer.sv
module tb_vector_sequencer;

   localparam int STIM_W  = 18;
   localparam int RESP_W  = 24;
   localparam int NUM_VEC = 4;
   localparam int SETTLE  = 2;
   localparam int CNT_W   = 2;
   localparam int IDX_W   = 3;

`ifdef VSEQ_STOP_ON_ERR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   // word = {mask, exp, stim}; exp is the zero-extended stim so a loopback response matches
   localparam logic [65:0] W0 = {24'hFFFFFF, 24'h012345, 18'h12345};
   localparam logic [65:0] W1 = {24'hFFFFFF, 24'h00A5A5, 18'h0A5A5};
   localparam logic [65:0] W2 = {24'hFFFFFF, 24'h0000FF, 18'h000FF};
   localparam logic [65:0] W3 = {24'hFFFFFE, 24'h03C3C3, 18'h3C3C3};
   localparam logic [4*66-1:0] IMAGE = {W3, W2, W1, W0};

   logic              clk;
   logic              rst;
   logic              start;
   logic              abort;
   logic [STIM_W-1:0] stim_o;
   logic [RESP_W-1:0] resp_i;
   logic              busy;
   logic              done;
   logic              pass;
   logic [CNT_W-1:0]  err_count;
   logic [IDX_W-1:0]  first_err;
   logic [IDX_W-1:0]  vec_idx;

   logic              flip_all;
   logic [STIM_W-1:0] flip_stim;
   logic [RESP_W-1:0] flip_bits;

   int errors = 0;
   int checks = 0;

   // board model: response echoes the stimulus, with selected bits corrupted on demand
   assign resp_i = {{(RESP_W-STIM_W){1'b0}}, stim_o}
                   ^ ((flip_all || (flip_stim == stim_o)) ? flip_bits : {RESP_W{1'b0}});

   vector_sequencer #(
      .STIM_W   (STIM_W),
      .RESP_W   (RESP_W),
      .NUM_VEC  (NUM_VEC),
      .SETTLE   (SETTLE),
      .CNT_W    (CNT_W),
      .ROM_IMAGE(IMAGE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .stim_o   (stim_o),
      .resp_i   (resp_i),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_count(err_count),
      .first_err(first_err),
      .vec_idx  (vec_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // start a run and count the sampled cycles with busy high (bounded)
   task automatic run_count(output int n);
      n = 0;
      pulse_start();
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++; if (stim_o !== 18'h0) begin errors++; $display("FAIL reset_stim got=%h want=0", stim_o); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b want=0", pass); end
      checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL reset_err got=%0d want=0", err_count); end
      checks++; if (first_err !== 3'd4) begin errors++; $display("FAIL reset_first got=%0d want=4", first_err); end
      checks++; if (vec_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", vec_idx); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_all_pass();
      int n;
      flip_bits = '0;
      run_count(n);
      checks++; if (n !== 16) begin errors++; $display("FAIL pass_busy_cycles got=%0d want=16", n); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL pass_done got=%b want=1", done); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pass_pass got=%b want=1", pass); end
      checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL pass_err got=%0d want=0", err_count); end
      checks++; if (first_err !== 3'd4) begin errors++; $display("FAIL pass_first got=%0d want=4", first_err); end
      checks++; if (vec_idx !== 3'd3) begin errors++; $display("FAIL pass_idx got=%0d want=3", vec_idx); end
      checks++; if (stim_o !== 18'h3C3C3) begin errors++; $display("FAIL pass_last_stim got=%h want=3c3c3", stim_o); end
   endtask

   task automatic test_mismatch();
      int n;
      flip_stim = 18'h000FF;
      flip_bits = 24'h000001;
      run_count(n);
      checks++; if (n !== (STOP ? 12 : 16)) begin errors++; $display("FAIL mism_busy_cycles got=%0d want=%0d", n, STOP ? 12 : 16); end
      checks++; if (err_count !== 2'd1) begin errors++; $display("FAIL mism_err got=%0d want=1", err_count); end
      checks++; if (first_err !== 3'd2) begin errors++; $display("FAIL mism_first got=%0d want=2", first_err); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mism_pass got=%b want=0", pass); end
      checks++; if (vec_idx !== (STOP ? 3'd2 : 3'd3)) begin errors++; $display("FAIL mism_idx got=%0d want=%0d", vec_idx, STOP ? 2 : 3); end
   endtask

   task automatic test_mask();
      int n;
      flip_stim = 18'h3C3C3;
      flip_bits = 24'h000001;
      run_count(n);
      checks++; if (n !== 16) begin errors++; $display("FAIL mask_busy_cycles got=%0d want=16", n); end
      checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL mask_err got=%0d want=0", err_count); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL mask_pass got=%b want=1", pass); end
      checks++; if (first_err !== 3'd4) begin errors++; $display("FAIL mask_first got=%0d want=4", first_err); end
   endtask

   task automatic test_saturate();
      int n;
      flip_all  = 1'b1;
      flip_bits = 24'h000010;
      run_count(n);
      flip_all  = 1'b0;
      checks++; if (err_count !== (STOP ? 2'd1 : 2'd3)) begin errors++; $display("FAIL sat_err got=%0d want=%0d", err_count, STOP ? 1 : 3); end
      checks++; if (first_err !== 3'd0) begin errors++; $display("FAIL sat_first got=%0d want=0", first_err); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL sat_pass got=%b want=0", pass); end
      checks++; if (n !== (STOP ? 4 : 16)) begin errors++; $display("FAIL sat_busy_cycles got=%0d want=%0d", n, STOP ? 4 : 16); end
   endtask

   task automatic test_abort();
      flip_bits = '0;
      pulse_start();            // now in LOAD of vector 0
      @(negedge clk);
      start = 1'b1;             // sampled in SETTLE of vector 0: must be ignored
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1;             // sampled in SETTLE of vector 1
      @(negedge clk);
      abort = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done got=%b want=1", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL abort_pass got=%b want=0", pass); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
      checks++; if (vec_idx !== 3'd1) begin errors++; $display("FAIL abort_idx got=%0d want=1", vec_idx); end
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL startabort_state got done=%b busy=%b want done=1 busy=0", done, busy); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL startabort_pass got=%b want=0", pass); end
      checks++; if (vec_idx !== 3'd1) begin errors++; $display("FAIL startabort_idx got=%0d want=1", vec_idx); end
   endtask

   task automatic test_rst_mid();
      int n;
      flip_stim = 18'h12345;
      flip_bits = 24'h000010;
      pulse_start();
      repeat (7) @(negedge clk);   // CHECK of vector 1
      checks++; if (err_count !== 2'd1) begin errors++; $display("FAIL rst_pre_err got=%0d want=1", err_count); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
      checks++; if (stim_o !== 18'h0) begin errors++; $display("FAIL rst_stim got=%h want=0", stim_o); end
      checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL rst_err got=%0d want=0", err_count); end
      checks++; if (first_err !== 3'd4) begin errors++; $display("FAIL rst_first got=%0d want=4", first_err); end
      @(negedge clk);
      rst = 1'b0;
      flip_bits = '0;
      run_count(n);
      checks++; if (n !== 16) begin errors++; $display("FAIL rerun_busy_cycles got=%0d want=16", n); end
      checks++; if (pass !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL rerun_pass got pass=%b done=%b want 1 1", pass, done); end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      flip_all  = 1'b0;
      flip_stim = '0;
      flip_bits = '0;
      test_reset();
      test_all_pass();
      test_mismatch();
      test_mask();
      test_saturate();
      test_abort();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
